// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM download packer: FIFO entry layout, write FSM states, byte-mask codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package jtframe_prog_pkg;

    typedef struct packed {
        logic [1:0]  bank;
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } prog_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } wr_state_t;

    // Active-low byte enables, bit 0 is the low byte
    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO of SDRAM programming entries.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push while full is ignored (caller flags it); pop while empty is ignored.
module jtframe_prog_fifo
    import jtframe_prog_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  prog_entry_t push_dat,
    input  logic        pop,
    output prog_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 1 << FIFO_AW;

    prog_entry_t          mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     cnt;
    logic                 push_ok;
    logic                 pop_ok;

    // Occupancy never exceeds DEPTH, so its top bit is set only when full
    assign full    = cnt[FIFO_AW];
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Packs the byte-wide ioctl download stream into 16-bit banked SDRAM writes.
// Latency: odd byte strobe at N -> FIFO at N+1 -> prog_we at N+2 (idle, empty FIFO).
// Backpressure: prog_we held until prog_rdy; FIFO overflow drops the entry and sets dwnld_err.
module jtframe_prog_packer
    import jtframe_prog_pkg::*;
#(
    parameter logic [24:0] BA1_START = 25'h040_0000,
    parameter logic [24:0] BA2_START = 25'h080_0000,
    parameter logic [24:0] BA3_START = 25'h0C0_0000,
    parameter int          FIFO_AW   = 2
) (
    input  logic        clk_rom,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_bank,
    output logic        prog_we,
    output logic        prog_rd,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        dwnld_err
);

    logic [1:0]  bank;
    logic [22:0] bank_start;
    logic [22:0] offset;
    logic [21:0] word;
    logic        lane;

    logic        pend_vld;
    logic [1:0]  pend_bank;
    logic [21:0] pend_addr;
    logic [7:0]  pend_byte;
    logic        match;

    logic        hold_vld;
    prog_entry_t hold_ent;

    prog_entry_t lo_ent;
    prog_entry_t hi_ent;
    prog_entry_t word_ent;
    prog_entry_t push_ent;
    logic        push;
    logic        hold_set;
    logic        pend_load;
    logic        pend_clr;

    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;

    wr_state_t   state;
    prog_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    assign prog_rd = 1'b0;
    assign dl_rise = downloading && !dl_q;
    assign dl_fall = !downloading && dl_q;

    always_comb begin
        bank       = 2'd0;
        bank_start = '0;
        if (ioctl_addr >= BA3_START) begin
            bank       = 2'd3;
            bank_start = BA3_START[22:0];
        end else if (ioctl_addr >= BA2_START) begin
            bank       = 2'd2;
            bank_start = BA2_START[22:0];
        end else if (ioctl_addr >= BA1_START) begin
            bank       = 2'd1;
            bank_start = BA1_START[22:0];
        end
    end

    // Bits above 22 of the offset never reach the word address, so the
    // subtraction is kept to the bits that matter
    assign offset = ioctl_addr[22:0] - bank_start;
    assign word   = offset[22:1];
    assign lane   = offset[0];
    assign match  = pend_vld && (pend_bank == bank) && (pend_addr == word);

    always_comb begin
        lo_ent      = '0;
        lo_ent.bank = pend_bank;
        lo_ent.addr = pend_addr;
        lo_ent.data = {8'h00, pend_byte};
        lo_ent.mask = MASK_LO;

        hi_ent      = '0;
        hi_ent.bank = bank;
        hi_ent.addr = word;
        hi_ent.data = {ioctl_data, 8'h00};
        hi_ent.mask = MASK_HI;

        word_ent      = '0;
        word_ent.bank = bank;
        word_ent.addr = word;
        word_ent.data = {ioctl_data, pend_byte};
        word_ent.mask = MASK_WORD;
    end

    // A deferred second push always wins; new strobes are at least 4 cycles apart
    always_comb begin
        push      = 1'b0;
        push_ent  = lo_ent;
        hold_set  = 1'b0;
        pend_load = 1'b0;
        pend_clr  = 1'b0;
        if (hold_vld) begin
            push     = 1'b1;
            push_ent = hold_ent;
        end else if (ioctl_wr) begin
            if (lane) begin
                pend_clr = 1'b1;
                push     = 1'b1;
                if (match) begin
                    push_ent = word_ent;
                end else if (pend_vld) begin
                    push_ent = lo_ent;
                    hold_set = 1'b1;
                end else begin
                    push_ent = hi_ent;
                end
            end else begin
                pend_load = 1'b1;
                push      = pend_vld;
                push_ent  = lo_ent;
            end
        end else if (dl_fall && pend_vld) begin
            push     = 1'b1;
            push_ent = lo_ent;
            pend_clr = 1'b1;
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_bank <= '0;
            pend_addr <= '0;
            pend_byte <= '0;
            hold_vld  <= 1'b0;
            hold_ent  <= '0;
        end else begin
            if (pend_load) begin
                pend_vld  <= 1'b1;
                pend_bank <= bank;
                pend_addr <= word;
                pend_byte <= ioctl_data;
            end else if (pend_clr) begin
                pend_vld  <= 1'b0;
            end
            hold_vld <= hold_set;
            if (hold_set) begin
                hold_ent <= hi_ent;
            end
        end
    end

    jtframe_prog_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk_rom),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pop = (state == WRITE) && prog_rdy;

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_bank <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        prog_bank <= head.bank;
                        prog_addr <= head.addr;
                        prog_data <= head.data;
                        prog_mask <= head.mask;
                        prog_we   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            dl_q       <= 1'b0;
            dwnld_busy <= 1'b0;
            dwnld_err  <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (dl_rise) begin
                dwnld_err <= 1'b0;
            end else if (push && fifo_full) begin
                dwnld_err <= 1'b1;
            end
            if (dl_rise) begin
                dwnld_busy <= 1'b1;
            end else if (!downloading && !pend_vld && !hold_vld && fifo_empty && state == IDLE) begin
                dwnld_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Directed bench for jtframe_prog_packer with a two-entry FIFO.
module tb_jtframe_prog_packer;

    logic        clk_rom;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_bank;
    logic        prog_we;
    logic        prog_rd;
    logic        prog_rdy;
    logic        dwnld_busy;
    logic        dwnld_err;

    int n_chk;
    int n_fail;

    jtframe_prog_packer #(
        .FIFO_AW (1)
    ) dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_bank   (prog_bank),
        .prog_we     (prog_we),
        .prog_rd     (prog_rd),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .dwnld_err   (dwnld_err)
    );

    initial clk_rom = 1'b0;
    always #5 clk_rom = ~clk_rom;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_rom);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        cyc(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic rdy_pulse();
        prog_rdy = 1'b1;
        cyc(1);
        prog_rdy = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [1:0] b, input logic [21:0] a,
                             input logic [15:0] d, input logic [1:0] m);
        chk({tag, "_we"},   32'(prog_we),   32'h1);
        chk({tag, "_bank"}, 32'(prog_bank), 32'(b));
        chk({tag, "_addr"}, 32'(prog_addr), 32'(a));
        chk({tag, "_data"}, 32'(prog_data), 32'(d));
        chk({tag, "_mask"}, 32'(prog_mask), 32'(m));
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_data  = '0;
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b0;
        cyc(2);

        chk("rst_we",   32'(prog_we),    32'h0);
        chk("rst_mask", 32'(prog_mask),  32'h3);
        chk("rst_addr", 32'(prog_addr),  32'h0);
        chk("rst_data", 32'(prog_data),  32'h0);
        chk("rst_bank", 32'(prog_bank),  32'h0);
        chk("rst_rd",   32'(prog_rd),    32'h0);
        chk("rst_busy", 32'(dwnld_busy), 32'h0);
        chk("rst_err",  32'(dwnld_err),  32'h0);

        rst = 1'b0;
        cyc(1);
        downloading = 1'b1;
        cyc(1);
        chk("busy_rise", 32'(dwnld_busy), 32'h1);

        // Even then odd byte of the same word: one full-word write
        wr_byte(25'h000010, 8'h34);
        cyc(3);
        chk("pair_no_we", 32'(prog_we), 32'h0);
        wr_byte(25'h000011, 8'h12);
        chk("pair_we_n1", 32'(prog_we), 32'h0);
        cyc(1);
        chk_write("pair", 2'd0, 22'h8, 16'h1234, 2'b00);
        cyc(1);
        chk("pair_we_hold", 32'(prog_we), 32'h1);
        chk("pair_data_hold", 32'(prog_data), 32'h1234);
        rdy_pulse();
        chk("pair_we_drop", 32'(prog_we), 32'h0);
        cyc(3);

        // Lone odd byte in bank 1, minimum 3-cycle write
        wr_byte(25'h040_0003, 8'hAB);
        cyc(1);
        chk_write("hi_b1", 2'd1, 22'h1, 16'hAB00, 2'b01);
        rdy_pulse();
        chk("hi_b1_drop", 32'(prog_we), 32'h0);
        cyc(3);

        // Even byte then unrelated odd byte: two pushes, lo first
        wr_byte(25'h000030, 8'h11);
        cyc(4);
        wr_byte(25'h000041, 8'h22);
        cyc(1);
        chk_write("split_lo", 2'd0, 22'h18, 16'h0011, 2'b10);
        rdy_pulse();
        cyc(2);
        chk_write("split_hi", 2'd0, 22'h20, 16'h2200, 2'b01);
        rdy_pulse();
        cyc(3);

        // Pending even byte flushed on downloading falling edge
        wr_byte(25'h000020, 8'h5A);
        cyc(4);
        chk("flush_no_we", 32'(prog_we), 32'h0);
        downloading = 1'b0;
        cyc(1);
        chk("flush_busy0", 32'(dwnld_busy), 32'h1);
        cyc(1);
        chk_write("flush", 2'd0, 22'h10, 16'h005A, 2'b10);
        rdy_pulse();
        chk("flush_busy_gap", 32'(dwnld_busy), 32'h1);
        cyc(1);
        chk("flush_busy_idle", 32'(dwnld_busy), 32'h1);
        cyc(1);
        chk("flush_busy_fall", 32'(dwnld_busy), 32'h0);

        // Overflow with prog_rdy stalled: first two words survive
        downloading = 1'b1;
        cyc(1);
        chk("ovf_err_clr", 32'(dwnld_err), 32'h0);
        for (int i = 0; i < 6; i++) begin
            wr_byte(25'h000101 + 25'(2 * i), 8'(i + 1));
            cyc(4);
        end
        chk("ovf_err", 32'(dwnld_err), 32'h1);
        chk_write("ovf_w0", 2'd0, 22'h80, 16'h0100, 2'b01);
        rdy_pulse();
        cyc(2);
        chk_write("ovf_w1", 2'd0, 22'h81, 16'h0200, 2'b01);
        rdy_pulse();
        cyc(3);
        chk("ovf_no_third", 32'(prog_we), 32'h0);
        chk("ovf_err_sticky", 32'(dwnld_err), 32'h1);

        // Reset in the middle of a write
        wr_byte(25'h200001, 8'h77);
        cyc(1);
        chk("mid_we", 32'(prog_we), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",   32'(prog_we),    32'h0);
        chk("mid_rst_busy", 32'(dwnld_busy), 32'h0);
        chk("mid_rst_err",  32'(dwnld_err),  32'h0);
        chk("mid_rst_mask", 32'(prog_mask),  32'h3);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_busy", 32'(dwnld_busy), 32'h1);
        cyc(2);
        chk("post_rst_fifo_empty", 32'(prog_we), 32'h0);

        // Fresh download into bank 3
        wr_byte(25'h0C0_0004, 8'hCD);
        cyc(4);
        wr_byte(25'h0C0_0005, 8'hEF);
        cyc(1);
        chk_write("fresh_b3", 2'd3, 22'h2, 16'hEFCD, 2'b00);
        rdy_pulse();
        downloading = 1'b0;
        begin
            int budget;
            budget = 20;
            while (dwnld_busy && budget > 0) begin
                cyc(1);
                budget--;
            end
        end
        chk("final_busy", 32'(dwnld_busy), 32'h0);
        chk("final_we",   32'(prog_we),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_prog_packer.md
# jtframe_prog_packer

Converts the byte-wide ROM download stream from the MiST SPI loader (ioctl_*) into 16-bit SDRAM programming writes (prog_*) for the board SDRAM controller. It maps each byte to an SDRAM bank and word address, pairs bytes into words, and buffers them in a small FIFO. It runs the prog_we/prog_rdy handshake and drives dwnld_busy, so game reset is held until the last word is in SDRAM.

## Interface
Parameters:
- BA1_START, 25'h040_0000: first byte address mapped to bank 1.
- BA2_START, 25'h080_0000: first byte address mapped to bank 2.
- BA3_START, 25'h0C0_0000: first byte address mapped to bank 3.
- FIFO_AW, 2: FIFO address width; depth is 2**FIFO_AW entries.

Ports:
- clk_rom  in  1: SDRAM-domain clock; everything is synchronous to it.
- rst  in  1: asynchronous, active-high reset.
- downloading  in  1: loader active.
- ioctl_addr  in  25: byte address.
- ioctl_data  in  8: byte data.
- ioctl_wr  in  1: one-cycle byte strobe.
- prog_addr  out  22: word address within the bank.
- prog_data  out  16: write data.
- prog_mask  out  2: active-low byte enables; bit 0 is the low byte.
- prog_bank  out  2: target bank.
- prog_we  out  1: write request.
- prog_rd  out  1: constant 0.
- prog_rdy  in  1: SDRAM write done. One-cycle pulse.
- dwnld_busy  out  1: download or drain in progress.
- dwnld_err  out  1: sticky FIFO overflow flag.

## Operation
- Bank select uses the highest start address ≤ ioctl_addr; if ioctl_addr is below BA1_START, the bank is 0.
- offset = ioctl_addr − bank start, computed in 25 bits. Word address = offset[22:1]. Byte lane = offset[0].
- Pairing register holds {bank, word addr, low byte, valid}:
  - Even byte, pairing register empty: store the byte; no push.
  - Odd byte whose bank and word match the pending even byte: push {data = odd byte, even byte; mask 2'b00}; clear the pairing register.
  - Odd byte with no matching pending byte: push any pending even byte first as mask 2'b10, data {8'h00, byte}. Then push the odd byte as mask 2'b01, data {byte, 8'h00}.
  - Even byte while another even byte is pending: flush the old one (mask 2'b10), then store the new one.
- Flush: on the downloading falling edge, a pending even byte is pushed as mask 2'b10.
- Two pushes from one strobe are spread over two consecutive cycles. The next ioctl_wr is ≥4 cycles away, so this never collides with new input.
- FIFO entry = {bank, addr, data, mask}.
  - A push while the FIFO is full is dropped and sets dwnld_err.
  - dwnld_err clears only on reset or on the downloading rising edge.
- Write FSM:
  - IDLE: if the FIFO is non-empty, load the head onto prog_*, assert prog_we, go to WRITE.
  - WRITE: hold prog_we and all prog_* stable until prog_rdy; then pop, drop prog_we, go to GAP.
  - GAP: one cycle with prog_we low, then IDLE.
- dwnld_busy:
  - Set on the downloading rising edge.
  - Cleared when downloading is low, the pairing register is empty, the FIFO is empty, and the FSM is in IDLE, with a 1-cycle registered delay.
- Reset mid-operation clears everything; the interrupted write is lost.
- Reset values: prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_bank=0, prog_rd=0, dwnld_busy=0, dwnld_err=0. The FSM is in IDLE and the FIFO is empty.

## Timing
- An odd byte strobe at cycle N pushes in N+1. With the FSM in IDLE and the FIFO empty, prog_we rises at N+2.
- Minimum write cycle is 3 clocks: IDLE → WRITE with prog_rdy in the same cycle → GAP.
- A push and a pop in the same cycle are both honoured; the FIFO occupancy count is unchanged.
- prog_rdy outside WRITE is ignored.
- dwnld_busy falls exactly 1 cycle after its clear condition first holds.
- All outputs are registered.

## Structure
- Package jtframe_prog_pkg: typedef prog_entry_t (bank[1:0], addr[21:0], data[15:0], mask[1:0]); FSM enum {IDLE, WRITE, GAP}; mask constants MASK_WORD=2'b00, MASK_LO=2'b10, MASK_HI=2'b01.
- Sub-module jtframe_prog_fifo: synchronous FIFO of prog_entry_t, parameter FIFO_AW, with push/pop/full/empty. A simultaneous push and pop is legal.
- Top level: bank map, pairing register, flush logic, FSM, busy/error flags.

## Test plan
- Byte 8'h34 at 25'h000010, then 8'h12 at 25'h000011; prog_rdy 2 cycles after prog_we → one write: bank 0, addr 22'h8, data 16'h1234, mask 2'b00; prog_we high 2 cycles.
- Byte at 25'h040_0003 → bank 1, addr 22'h1, mask 2'b01, data[15:8] = the byte.
- Even byte at 25'h000020, then downloading falls → flush write: addr 22'h10, mask 2'b10. dwnld_busy falls 1 cycle after the write completes.
- prog_rdy held low while 6 bytes arrive with FIFO_AW=1 → dwnld_err=1. The first 2 words are retained and written in order once prog_rdy returns.
- Reset asserted while in WRITE → prog_we drops asynchronously, the FIFO empties, dwnld_busy=0. A fresh download then works normally.
